// File: rtl/piso_pkg.sv
// piso_pkg: shared FSM state type and sizing helper for the PISO serializer
//   state_t : IDLE / SHIFT / PARITY encoding
//   cnt_w() : bit-counter width for a given word width
package piso_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/piso_serializer_tx_shift_stage.sv
// piso_shift_stage: one storage bit of the serializer, 2:1 load/shift select into an async-clear flop
//   clk, rst_n : clock, asynchronous active-low clear
//   i_en       : update enable (holds value when low)
//   i_sel      : 1 = take i_load_d, 0 = take i_shift_d
//   i_load_d   : parallel load bit
//   i_shift_d  : neighbour bit for shifting
//   o_q        : stored bit
module piso_shift_stage (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_sel,
  input  logic i_load_d,
  input  logic i_shift_d,
  output logic o_q
);
  logic w_d;
  assign w_d = i_en ? (i_sel ? i_load_d : i_shift_d) : o_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) o_q <= 1'b0;
    else        o_q <= w_d;
endmodule

// File: rtl/piso_serializer_tx.sv
// piso_serializer_tx: parallel-in serial-out transmitter with valid/ready load and zero-gap frames
//   clk, rst_n   : clock, asynchronous active-low reset
//   din          : parallel word, captured when load_valid && load_ready
//   load_valid   : producer has a word
//   load_ready   : combinational; high in IDLE and in the final cycle of a frame
//   sout         : registered serial bit (0 when idle)
//   sout_valid   : sout carries a frame bit
//   frame_start  : first bit of a frame
//   busy         : frame in flight
// Optional: define PISO_PARITY_EN to append an even-parity bit after each word.
module piso_serializer_tx
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             busy
);
  localparam int CW = cnt_w(WIDTH);
  state_t           r_state, w_state_nx;
  logic [CW-1:0]    r_cnt, w_cnt_nx;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] w_load_d, w_shift_d;
  logic             r_sout, w_sout_nx;
  logic             r_frame_start;
  logic             w_last, w_xfer, w_adv, w_first, w_sr_out, w_sr_en;
`ifdef PISO_PARITY_EN
  logic             r_par;
`endif
  // The first bit goes straight to sout at the load edge, so the register
  // captures the word already advanced by one position.
  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_stage
      if (MSB_FIRST) begin : g_msb
        assign w_load_d[i]  = (i == 0) ? 1'b0 : din[(i == 0) ? 0 : i-1];
        assign w_shift_d[i] = (i == 0) ? 1'b0 : r_sr[(i == 0) ? 0 : i-1];
      end else begin : g_lsb
        assign w_load_d[i]  = (i == WIDTH-1) ? 1'b0 : din[(i == WIDTH-1) ? i : i+1];
        assign w_shift_d[i] = (i == WIDTH-1) ? 1'b0 : r_sr[(i == WIDTH-1) ? i : i+1];
      end
      piso_shift_stage u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (w_sr_en),
        .i_sel     (w_xfer),
        .i_load_d  (w_load_d[i]),
        .i_shift_d (w_shift_d[i]),
        .o_q       (r_sr[i])
      );
    end
  endgenerate
  assign w_first  = MSB_FIRST ? din[WIDTH-1]  : din[0];
  assign w_sr_out = MSB_FIRST ? r_sr[WIDTH-1] : r_sr[0];
  always_comb begin
    w_last     = (r_state == SHIFT) && (r_cnt == CW'(WIDTH-1));
    w_adv      = (r_state == SHIFT) && !w_last;
`ifdef PISO_PARITY_EN
    load_ready = (r_state == IDLE) || (r_state == PARITY);
`else
    load_ready = (r_state == IDLE) || w_last;
`endif
    w_xfer     = load_valid && load_ready;
    w_sr_en    = w_xfer || (r_state == SHIFT);
    w_cnt_nx   = (w_adv && !w_xfer) ? r_cnt + CW'(1) : '0;
`ifdef PISO_PARITY_EN
    w_state_nx = (w_xfer || w_adv) ? SHIFT : w_last ? PARITY : IDLE;
    w_sout_nx  = w_xfer ? w_first : w_adv ? w_sr_out : w_last ? r_par : 1'b0;
`else
    w_state_nx = (w_xfer || w_adv) ? SHIFT : IDLE;
    w_sout_nx  = w_xfer ? w_first : w_adv ? w_sr_out : 1'b0;
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_sout        <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_cnt         <= w_cnt_nx;
      r_sout        <= w_sout_nx;
      r_frame_start <= w_xfer;
    end
`ifdef PISO_PARITY_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)      r_par <= 1'b0;
    else if (w_xfer) r_par <= ^din;
`endif
  assign sout        = r_sout;
  assign sout_valid  = (r_state != IDLE);
  assign busy        = (r_state != IDLE);
  assign frame_start = r_frame_start;
endmodule

// File: tb/tb_piso_serializer_tx.sv
// tb_piso_serializer_tx: scoreboard bench driving an MSB-first and an LSB-first serializer in lockstep
module tb_piso_serializer_tx;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = 8'h00;
  logic       lv = 1'b0;
  logic       rdy_m, so_m, sv_m, fs_m, bz_m;
  logic       rdy_l, so_l, sv_l, fs_l, bz_l;
  always #5 clk = ~clk;

  piso_serializer_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .din(din), .load_valid(lv), .load_ready(rdy_m),
    .sout(so_m), .sout_valid(sv_m), .frame_start(fs_m), .busy(bz_m));
  piso_serializer_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .din(din), .load_valid(lv), .load_ready(rdy_l),
    .sout(so_l), .sout_valid(sv_l), .frame_start(fs_l), .busy(bz_l));

`ifdef PISO_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  typedef struct {logic [7:0] w; logic p; int k;} slot_t;
  typedef struct {logic [7:0] din; logic exp_par; int gap;} vec_t;

  slot_t q[$];
  slot_t cur;
  bit    cur_v = 1'b0;
  bit    last_xfer;
  int    n_pass = 0, n_tot = 0;

  function automatic bit m_ready();
    return !cur_v || (q.size() == 0);
  endfunction

  task automatic chk(input string nm, input logic act, input logic exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
  endtask

  task automatic check_all(input bit with_ready);
    logic em, el;
    em = cur_v ? ((cur.k == 8) ? cur.p : cur.w[7-cur.k]) : 1'b0;
    el = cur_v ? ((cur.k == 8) ? cur.p : cur.w[cur.k])   : 1'b0;
    chk("msb_sout",  so_m, em);
    chk("lsb_sout",  so_l, el);
    chk("msb_valid", sv_m, cur_v);
    chk("lsb_valid", sv_l, cur_v);
    chk("msb_fs",    fs_m, cur_v && cur.k == 0);
    chk("lsb_fs",    fs_l, cur_v && cur.k == 0);
    chk("msb_busy",  bz_m, cur_v);
    chk("lsb_busy",  bz_l, cur_v);
    if (with_ready) begin
      chk("msb_ready", rdy_m, m_ready());
      chk("lsb_ready", rdy_l, m_ready());
    end
  endtask

  task automatic step(input logic p);
    bit x;
    x = lv && m_ready();
    @(posedge clk);
    if (x) for (int k = 0; k < NB; k++) q.push_back('{w: din, p: p, k: k});
    cur_v = (q.size() > 0);
    if (cur_v) cur = q.pop_front();
    last_xfer = x;
    #1 check_all(1'b1);
  endtask

  // Present a word, hold it until accepted, then idle the input for gap cycles
  // while scrambling din to show unaccepted data has no effect.
  task automatic send(input logic [7:0] w, input logic p, input int gap);
    bit done = 1'b0;
    din = w;
    lv  = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      step(p);
      done = last_xfer;
    end
    if (!done) begin
      n_tot++;
      $display("FAIL accept_timeout: word %h not accepted within 20 cycles", w);
    end
    lv = 1'b0;
    for (int g = 0; g < gap; g++) begin
      din = 8'($urandom);
      step(1'b0);
    end
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{8'hA5, 1'b0, 10};
    tbl[1] = '{8'h07, 1'b1, 0};
    tbl[2] = '{8'h5A, 1'b0, 2};
    tbl[3] = '{8'hFF, 1'b0, 0};
    tbl[4] = '{8'h00, 1'b0, 10};
    tbl[5] = '{8'h81, 1'b0, 1};
    tbl[6] = '{8'hFE, 1'b1, 0};
    tbl[7] = '{8'h01, 1'b1, 10};

    repeat (3) @(posedge clk);
    #1 check_all(1'b0);
    @(negedge clk) rst_n = 1'b1;
    #1 check_all(1'b1);

    foreach (tbl[i]) send(tbl[i].din, tbl[i].exp_par, tbl[i].gap);

    // Word offered mid-frame while not ready: must wait for the final-cycle edge.
    send(8'hA5, 1'b0, 3);
    send(8'h3C, 1'b0, 12);

    // Asynchronous abort in cycle 5 of a frame, then a clean frame.
    send(8'hA5, 1'b0, 4);
    #1 rst_n = 1'b0;
    q.delete();
    cur_v = 1'b0;
    #1 check_all(1'b0);
    @(negedge clk) rst_n = 1'b1;
    #1 check_all(1'b1);
    send(8'h81, 1'b0, 12);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
